apb_register_bank: RTL
======================

# apb_register_bank

APB slave register bank that sits directly upstream of the encoder/decoder core and its golden model. It holds the four configuration registers (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE), serves APB reads and writes, and emits the `RegistersW`/`RegistersR` strobes. On a legal CTRL write it issues a one-cycle `start` pulse to the core, then stalls further APB writes until the core reports `operation_done` or a watchdog expires.

## Interface
- `DATA_WIDTH`, 32, core data width (informational; registers are `AMBA_WORD` wide)
- `AMBA_ADDR_WIDTH`, 20, APB address width
- `AMBA_WORD`, 32, APB data/register width
- `TIMEOUT`, 1024, maximum busy cycles before the watchdog fires (≥2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `PADDR`  in  AMBA_ADDR_WIDTH  APB address; only [3:2] decoded
- `PSEL`  in  1  APB select
- `PENABLE`  in  1  APB access phase
- `PWRITE`  in  1  1 = write, 0 = read
- `PWDATA`  in  AMBA_WORD  write data
- `PRDATA`  out  AMBA_WORD  read data
- `PREADY`  out  1  transfer completion / wait-state control
- `RegistersW`  out  1  one-cycle strobe on write completion
- `RegistersR`  out  1  one-cycle strobe on read completion
- `ctrl`, `data_in`, `codeword_width`, `noise`  out  AMBA_WORD each  register contents to core
- `start`  out  1  one-cycle operation request to core
- `busy`  out  1  operation in flight
- `timeout_err`  out  1  sticky watchdog flag
- `operation_done`  in  1  core completion pulse

## Operation
- Register map by PADDR[3:2]: 00 CTRL, 01 DATA_IN, 10 CODEWORD_WIDTH, 11 NOISE. Other address bits are ignored, so aliases are legal.
- The APB state machine has three states:
  - IDLE → SETUP when `PSEL`=1 and `PENABLE`=0.
  - SETUP → ACCESS on the next cycle.
  - ACCESS → IDLE (or SETUP for back-to-back transfers) when `PREADY`=1.
  - ACCESS holds while `PREADY`=0.
- Write: the register is updated on the edge where `PSEL & PENABLE & PWRITE & PREADY`, with the full `PWDATA` stored.
- Read: `PRDATA` is loaded from the selected register at the end of SETUP and held until the next read. `PRDATA` does not change during writes.
- `PREADY` is combinational:
  - reads: always 1 (zero wait states);
  - writes: `~busy` (writes stall while an operation is in flight).
- Start generation: a completed write to CTRL with CTRL[1:0] in {00, 01, 10} asserts `start` for exactly one cycle, on the cycle after the write edge, and sets `busy` at the same edge.
  - CTRL[1:0]=11: the register is still updated, but there is no `start` and `busy` is unchanged.
- Busy/watchdog:
  - While `busy`, a counter increments each cycle.
  - `operation_done` sampled high clears `busy` and the counter on that edge.
  - If the counter reaches `TIMEOUT-1` without `operation_done`, `busy` clears and `timeout_err` sets.
  - `timeout_err` clears on the next completed CTRL write.
  - `operation_done` while not busy is ignored.
- Simultaneous `operation_done` and watchdog expiry on the same edge: done wins, and `timeout_err` is not set.
- Reset mid-operation: all state is cleared immediately and asynchronously. An APB transfer in progress is abandoned; the master restarts it.

## Timing
- Reset values: all registers, `PRDATA`, `RegistersW`, `RegistersR`, `start`, `busy`, `timeout_err`, and the counter are 0. The FSM is in IDLE. `PREADY` evaluates to 1.
- Write latency: the register output changes 1 cycle after the ACCESS edge. `RegistersW` is high for the cycle following the completion edge.
- `RegistersR` is high for the cycle following read completion.
- `start` goes high 1 cycle after the CTRL write edge. `busy` rises at the same edge and falls on the edge that samples `operation_done`.
- The earliest accepted APB write after `start` is in the cycle after `busy` falls. A write stalled in ACCESS completes in that cycle.
- Back-to-back reads run at 2 cycles per transfer.

## Test plan
- Reset, then read all four offsets → `PRDATA`=0x00000000 each, `PREADY`=1, no wait states.
- Write 0x5A5A5A5A to offset 0x4, then read 0x4 and the alias 0x14 → both return 0x5A5A5A5A; `RegistersW` high for one cycle, `ctrl` unchanged.
- Write CTRL=0x1 → `start` for one cycle, `busy`=1. A write to NOISE issued during busy holds `PREADY`=0. `operation_done` pulse after 20 cycles → `busy`=0 and the NOISE write completes in the next cycle.
- Write CTRL=0x3 → `ctrl`=0x3, no `start`, `busy` stays 0.
- `TIMEOUT`=16, write CTRL=0x2 with no `operation_done` → `busy` falls after 16 cycles and `timeout_err`=1. The next CTRL=0x0 write clears `timeout_err` and pulses `start`.
- Assert `rst` low while busy with a write stalled → all outputs return to 0 immediately, `PREADY`=1, and no `start` appears after release.

Source files
------------

// File: rtl/apb_register_bank.sv
// APB slave holding the CTRL/DATA_IN/CODEWORD_WIDTH/NOISE configuration registers.
// It launches core operations on CTRL writes and stalls writes while an operation is in flight.
module apb_register_bank #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT         = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       RegistersW,
  output logic                       RegistersR,
  output logic [AMBA_WORD-1:0]       ctrl,
  output logic [AMBA_WORD-1:0]       data_in,
  output logic [AMBA_WORD-1:0]       codeword_width,
  output logic [AMBA_WORD-1:0]       noise,
  output logic                       start,
  output logic                       busy,
  output logic                       timeout_err,
  input  logic                       operation_done
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  apb_state_t           state;
  logic [CW-1:0]        cnt;
  logic [1:0]           sel;
  logic                 in_xfer;
  logic                 wr_done;
  logic                 rd_done;
  logic                 rd_setup;
  logic                 ctrl_wr;
  logic                 start_req;
  logic [AMBA_WORD-1:0] rdata;
  logic                 unused_ok;

  assign sel       = PADDR[3:2];
  assign unused_ok = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]} ^ (DATA_WIDTH > 0);

  assign PREADY    = PWRITE ? ~busy : 1'b1;

  // The registered state lags the bus by one phase: SETUP/ACCESS are the
  // first and stalled cycles of the bus access phase, so a completion is only
  // honoured once a setup phase has been seen (abandoned transfers are ignored).
  assign in_xfer   = (state != IDLE);
  assign wr_done   = PSEL & PENABLE & PWRITE & PREADY & in_xfer;
  assign rd_done   = PSEL & PENABLE & ~PWRITE & in_xfer;
  assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
  assign ctrl_wr   = wr_done & (sel == 2'b00);
  assign start_req = ctrl_wr & (PWDATA[1:0] != 2'b11);

  always_comb begin
    rdata = '0;
    case (sel)
      2'b00:   rdata = ctrl;
      2'b01:   rdata = data_in;
      2'b10:   rdata = codeword_width;
      default: rdata = noise;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      PRDATA         <= '0;
      RegistersW     <= 1'b0;
      RegistersR     <= 1'b0;
      ctrl           <= '0;
      data_in        <= '0;
      codeword_width <= '0;
      noise          <= '0;
      start          <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) state <= SETUP;
        end
        SETUP: begin
          if (!PSEL)                state <= IDLE;
          else if (!PENABLE)        state <= SETUP;
          else if (PREADY)          state <= IDLE;
          else                      state <= ACCESS;
        end
        ACCESS: begin
          if (!PSEL || PREADY)      state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      RegistersW <= wr_done;
      RegistersR <= rd_done;
      start      <= start_req;

      if (rd_setup) PRDATA <= rdata;

      if (wr_done) begin
        case (sel)
          2'b00:   ctrl           <= PWDATA;
          2'b01:   data_in        <= PWDATA;
          2'b10:   codeword_width <= PWDATA;
          default: noise          <= PWDATA;
        endcase
      end

      if (ctrl_wr) timeout_err <= 1'b0;

      // A CTRL write can only complete while idle, so it never races the watchdog.
      if (start_req) begin
        busy <= 1'b1;
        cnt  <= '0;
      end else if (busy) begin
        if (operation_done) begin
          busy <= 1'b0;
          cnt  <= '0;
        end else if (cnt == LAST) begin
          busy        <= 1'b0;
          cnt         <= '0;
          timeout_err <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
